// File: rtl/code_pkg.sv
// Shared constants and types for the dual-mode event counter.
// Imported by the prescaler and the top level.
package code_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int DIV_DEF   = 4;

  typedef logic [WIDTH_DEF-1:0] cnt_t;

  // Prescaler width; at least one bit.
  function automatic int pre_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/code_prescaler.sv
// Modulo-DIV counter; tick marks the enabled cycle that closes a group.
// The partial count survives idle and mode-switch cycles.
module code_prescaler
  import code_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick_en,
  output logic tick
);

  localparam int PW = pre_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre = '0;

  assign tick = tick_en && (pre == LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pre <= '0;
    end else if (tick_en) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/code.sv
// Dual-mode event counter: fast counter per enabled cycle,
// slow counter per DIV enabled cycles, selected by Slt.
module code
  import code_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV   = DIV_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Slt,
  input  logic             En,
  output logic [WIDTH-1:0] Output0,
  output logic [WIDTH-1:0] Output1
);

  logic [WIDTH-1:0] cnt0 = '0;
  logic [WIDTH-1:0] cnt1 = '0;
  logic             tick;

  code_prescaler #(
    .DIV(DIV)
  ) u_pre (
    .Clk    (Clk),
    .Reset  (Reset),
    .tick_en(En & Slt),
    .tick   (tick)
  );

  // Reset beats enable, enable beats mode.
  always_ff @(posedge Clk) begin
    priority case (1'b1)
      Reset: begin
        cnt0 <= '0;
        cnt1 <= '0;
      end
      !En: begin
      end
      !Slt: cnt0 <= cnt0 + 1'b1;
      default: begin
        if (tick) cnt1 <= cnt1 + 1'b1;
      end
    endcase
  end

  assign Output0 = cnt0;
  assign Output1 = cnt1;

endmodule

// File: tb/tb_code.sv
// Bench for the dual-mode counter: directed scenarios plus random
// traffic against an event-count reference model.
module tb_code;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b0;
  logic        Slt   = 1'b0;
  logic        En    = 1'b0;
  logic [63:0] out0;
  logic [63:0] out1;
  logic [3:0]  s0;
  logic [3:0]  s1;

  int compared   = 0;
  int mismatched = 0;

  // Model: fast events and slow events since the last reset.
  longint unsigned m0 = 0;
  longint unsigned g  = 0;

  code dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Slt    (Slt),
    .En     (En),
    .Output0(out0),
    .Output1(out1)
  );

  code #(
    .WIDTH(4),
    .DIV  (4)
  ) dut_s (
    .Clk    (Clk),
    .Reset  (Reset),
    .Slt    (Slt),
    .En     (En),
    .Output0(s0),
    .Output1(s1)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s,
                      input logic e, input bit gl = 0);
    Reset = r;
    Slt   = s;
    En    = e;
    if (gl) begin
      #2 Slt = ~s;
      #2 Slt = s;
    end
    @(posedge Clk);
    if (r) begin
      m0 = 0;
      g  = 0;
    end else if (e) begin
      if (s) g++;
      else   m0++;
    end
    #1;
    chk("out0", out0, m0);
    chk("out1", out1, g / 4);
    chk("s0", {60'd0, s0}, m0 % 16);
    chk("s1", {60'd0, s1}, (g / 4) % 16);
  endtask

  initial begin
    // Power-up without reset.
    for (int i = 0; i < 8; i++) step(0, 1, 1);
    chk("pwr_out1", out1, 64'd2);
    chk("pwr_out0", out0, 64'd0);

    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    chk("fast10", out0, 64'd10);
    chk("fast10_o1", out1, 64'd0);

    // Idle cycles keep the partial group.
    step(0, 1, 1);
    step(0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 1), 0);
    step(0, 1, 1);
    chk("idle_o1_pre", out1, 64'd0);
    step(0, 1, 1);
    chk("idle_o1", out1, 64'd1);

    // Mode-switch carry-over.
    step(1, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    chk("sw_o1", out1, 64'd1);
    chk("sw_o0", out0, 64'd3);

    // Reset mid-group.
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    step(1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    chk("rst_mid", out1, 64'd0);
    step(0, 1, 1);
    chk("rst_mid4", out1, 64'd1);

    // Inputs change only between edges.
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, i[0], 1, 1);
    chk("glitch_o0", out0, 64'd3);

    // Wrap on the narrow instance.
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    chk("wrap_s0", {60'd0, s0}, 64'd0);
    for (int i = 0; i < 64; i++) step(0, 1, 1);
    chk("wrap_s1", {60'd0, s1}, 64'd0);
    chk("wrap_o1", out1, 64'd16);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2),
           $urandom_range(0, 1),
           ($urandom_range(0, 9) < 8),
           $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
